// File: rtl/reg_bank_arbiter.sv
// Two-master register-bank arbiter: each master gets a one-deep request slot,
// slots are serialised onto the single bank port with round-robin priority.

module reg_bank_arbiter_slot #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              grant_i,
    input  logic              ovf_clr_i,
    output logic              valid_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              overflow_o
);

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        if (grant_i) begin
            valid_d = 1'b0;
        end
        // A slot granted this cycle is free again in time to take a new strobe.
        if (req_i && (!valid_q || grant_i)) begin
            valid_d = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else if (req_i && valid_q && !grant_i) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o    = valid_q;
    assign we_o       = we_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign overflow_o = ovf_q;

endmodule

module reg_bank_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_reg_en,
    input  logic              m0_write_en,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    output logic              m0_done,
    output logic              m0_busy,
    output logic              m0_overflow,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_reg_en,
    input  logic              m1_write_en,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic              m1_done,
    output logic              m1_busy,
    output logic              m1_overflow,
    input  logic              overflow_clr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_write_to_reg,
    input  logic [DATA_W-1:0] data_read_from_reg,
    output logic              reg_en,
    output logic              write_en,
    output logic [1:0]        grant_mon,
    output logic [1:0]        state_mon
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RWAIT = 2'd2;

    logic [1:0]             req, req_we, slot_v, slot_we, grant, ovf;
    logic [1:0][ADDR_W-1:0] req_addr, slot_addr;
    logic [1:0][DATA_W-1:0] req_wdata, slot_wdata;

    assign req       = {m1_reg_en, m0_reg_en};
    assign req_we    = {m1_write_en, m0_write_en};
    assign req_addr  = {m1_address, m0_address};
    assign req_wdata = {m1_wdata, m0_wdata};

    for (genvar m = 0; m < 2; m++) begin : g_slot
        reg_bank_arbiter_slot #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .resetb     (resetb),
            .req_i      (req[m]),
            .we_i       (req_we[m]),
            .addr_i     (req_addr[m]),
            .wdata_i    (req_wdata[m]),
            .grant_i    (grant[m]),
            .ovf_clr_i  (overflow_clr),
            .valid_o    (slot_v[m]),
            .we_o       (slot_we[m]),
            .addr_o     (slot_addr[m]),
            .wdata_o    (slot_wdata[m]),
            .overflow_o (ovf[m])
        );
    end

    logic [1:0]             state_q, state_d;
    logic                   gnt_q, gnt_d;
    logic                   last_q, last_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   reg_en_q, reg_en_d;
    logic                   we_q, we_d;
    logic [1:0]             done_q, done_d;
    logic [1:0]             rvalid_q, rvalid_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic sel, grant_any, in_flight;

    // On a tie the master that did not win last time goes first.
    assign sel       = (slot_v == 2'b11) ? ~last_q : slot_v[1];
    assign grant_any = (state_q == S_IDLE) && (|slot_v);
    assign grant     = grant_any ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign in_flight = (state_q == S_ISSUE) || (state_q == S_RWAIT);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        reg_en_d = 1'b0;
        we_d     = 1'b0;
        done_d   = 2'b00;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d  = S_ISSUE;
                    gnt_d    = sel;
                    last_d   = sel;
                    addr_d   = slot_addr[sel];
                    wdata_d  = slot_wdata[sel];
                    reg_en_d = 1'b1;
                    we_d     = slot_we[sel];
                    // done lands in the ISSUE cycle alongside the bank strobe.
                    done_d[sel] = slot_we[sel];
                end
            end
            S_ISSUE: begin
                state_d = we_q ? S_IDLE : S_RWAIT;
            end
            S_RWAIT: begin
                rdata_d[gnt_q]  = data_read_from_reg;
                rvalid_d[gnt_q] = 1'b1;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            reg_en_q <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 2'b00;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            reg_en_q <= reg_en_d;
            we_q     <= we_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    logic [1:0] busy;
    assign busy = slot_v | (in_flight ? (gnt_q ? 2'b10 : 2'b01) : 2'b00);

    assign m0_rdata          = rdata_q[0];
    assign m1_rdata          = rdata_q[1];
    assign m0_rvalid         = rvalid_q[0];
    assign m1_rvalid         = rvalid_q[1];
    assign m0_done           = done_q[0];
    assign m1_done           = done_q[1];
    assign m0_busy           = busy[0];
    assign m1_busy           = busy[1];
    assign m0_overflow       = ovf[0];
    assign m1_overflow       = ovf[1];
    assign address           = addr_q;
    assign data_write_to_reg = wdata_q;
    assign reg_en            = reg_en_q;
    assign write_en          = we_q;
    assign grant_mon         = {in_flight, gnt_q};
    assign state_mon         = state_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed table, corner sequences, and random
// traffic against a transaction-schedule reference model.

module tb_reg_bank_arbiter;

    logic       clk = 1'b0;
    logic       resetb;
    logic [7:0] m0_address, m0_wdata, m1_address, m1_wdata;
    logic       m0_reg_en, m0_write_en, m1_reg_en, m1_write_en;
    logic [7:0] m0_rdata, m1_rdata;
    logic       m0_rvalid, m0_done, m0_busy, m0_overflow;
    logic       m1_rvalid, m1_done, m1_busy, m1_overflow;
    logic       overflow_clr;
    logic [7:0] address, data_write_to_reg, data_read_from_reg;
    logic       reg_en, write_en;
    logic [1:0] grant_mon, state_mon;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .resetb(resetb),
        .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_reg_en(m0_reg_en),
        .m0_write_en(m0_write_en), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m0_done(m0_done), .m0_busy(m0_busy), .m0_overflow(m0_overflow),
        .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_reg_en(m1_reg_en),
        .m1_write_en(m1_write_en), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .m1_done(m1_done), .m1_busy(m1_busy), .m1_overflow(m1_overflow),
        .overflow_clr(overflow_clr), .address(address),
        .data_write_to_reg(data_write_to_reg),
        .data_read_from_reg(data_read_from_reg), .reg_en(reg_en),
        .write_en(write_en), .grant_mon(grant_mon), .state_mon(state_mon)
    );

    // Bank: registered read, contents re-seeded on reset.
    logic [7:0] seed = 8'h00;
    logic [7:0] mem [256];
    logic [7:0] rd_q;

    function automatic logic [7:0] init_val(input logic [7:0] a, input logic [7:0] s);
        if (s == 8'h00) begin
            if (a == 8'h22) return 8'h3C;
            if (a == 8'h02) return 8'h5A;
            return a ^ 8'hC3;
        end
        return (a * 8'd37) ^ s;
    endfunction

    always @(posedge clk) begin
        if (!resetb) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i), seed);
            rd_q <= 8'h00;
        end else if (reg_en) begin
            if (write_en) mem[address] <= data_write_to_reg;
            else rd_q <= mem[address];
        end
    end
    assign data_read_from_reg = rd_q;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        m0_reg_en = 0; m0_write_en = 0; m0_address = 0; m0_wdata = 0;
        m1_reg_en = 0; m1_write_en = 0; m1_address = 0; m1_wdata = 0;
        overflow_clr = 0;
    endtask

    task automatic drv0(input logic we, input logic [7:0] a, input logic [7:0] d);
        m0_reg_en = 1; m0_write_en = we; m0_address = a; m0_wdata = d;
    endtask

    task automatic drv1(input logic we, input logic [7:0] a, input logic [7:0] d);
        m1_reg_en = 1; m1_write_en = we; m1_address = a; m1_wdata = d;
    endtask

    task automatic do_reset();
        resetb = 0;
        idle();
        repeat (3) tick();
        resetb = 1;
    endtask

    // e_m0/e_m1 = {done, rvalid, busy}
    typedef struct {
        logic       m0_en, m0_we; logic [7:0] m0_a, m0_d;
        logic       m1_en, m1_we; logic [7:0] m1_a, m1_d;
        logic [1:0] st; logic ren, wen; logic [7:0] addr, wd;
        logic [2:0] e_m0, e_m1; logic [7:0] m1_rd;
    } vec_t;

    function automatic vec_t mk(input logic m0e, m0w, input logic [7:0] m0a, m0d,
                                input logic m1e, m1w, input logic [7:0] m1a, m1d,
                                input logic [1:0] st, input logic ren, wen,
                                input logic [7:0] a, wd, input logic [2:0] e0, e1,
                                input logic [7:0] rd);
        vec_t v;
        v.m0_en = m0e; v.m0_we = m0w; v.m0_a = m0a; v.m0_d = m0d;
        v.m1_en = m1e; v.m1_we = m1w; v.m1_a = m1a; v.m1_d = m1d;
        v.st = st; v.ren = ren; v.wen = wen; v.addr = a; v.wd = wd;
        v.e_m0 = e0; v.e_m1 = e1; v.m1_rd = rd;
        return v;
    endfunction

    vec_t tbl [18];

    task automatic observe(inout int acc, inout int dn, inout logic bad);
        if (reg_en && (address >= 8'h30) && (address <= 8'h32)) acc++;
        if (reg_en && address == 8'h32) bad = 1;
        if (m0_done) dn++;
    endtask

    // Reference-model storage for the random phase
    localparam int NC = 3600;
    logic       e_ren [NC];
    logic       e_wen [NC];
    logic [7:0] e_a   [NC];
    logic [7:0] e_d   [NC];
    logic [1:0] e_done[NC];
    logic [1:0] e_rv  [NC];
    logic [7:0] e_rd  [NC][2];
    logic [7:0] mmem  [256];

    initial begin
        int acc, dn; logic bad;
        int pulses;
        idle();
        do_reset();

        tbl[0]  = mk(1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 3'b000,3'b000,8'h00);
        tbl[1]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 3'b001,3'b000,8'h00);
        tbl[2]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,1,1,8'h10,8'hA5, 3'b101,3'b000,8'h00);
        tbl[3]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10,8'hA5, 3'b000,3'b000,8'h00);
        tbl[4]  = mk(0,0,8'h00,8'h00, 1,0,8'h22,8'h00, 0,0,0,8'h10,8'hA5, 3'b000,3'b000,8'h00);
        tbl[5]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10,8'hA5, 3'b000,3'b001,8'h00);
        tbl[6]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,1,0,8'h22,8'h00, 3'b000,3'b001,8'h00);
        tbl[7]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2,0,0,8'h22,8'h00, 3'b000,3'b001,8'h00);
        tbl[8]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h22,8'h00, 3'b000,3'b010,8'h3C);
        tbl[9]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h22,8'h00, 3'b000,3'b000,8'h3C);
        tbl[10] = mk(1,1,8'h01,8'h11, 1,0,8'h02,8'h00, 0,0,0,8'h22,8'h00, 3'b000,3'b000,8'h3C);
        tbl[11] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h22,8'h00, 3'b001,3'b001,8'h3C);
        tbl[12] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,1,1,8'h01,8'h11, 3'b101,3'b001,8'h3C);
        tbl[13] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h01,8'h11, 3'b000,3'b001,8'h3C);
        tbl[14] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,1,0,8'h02,8'h00, 3'b000,3'b001,8'h3C);
        tbl[15] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2,0,0,8'h02,8'h00, 3'b000,3'b001,8'h3C);
        tbl[16] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h02,8'h00, 3'b000,3'b010,8'h5A);
        tbl[17] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h02,8'h00, 3'b000,3'b000,8'h5A);

        for (int i = 0; i < 18; i++) begin
            chk($sformatf("tbl%0d_bank", i),
                {state_mon, reg_en, write_en, address, data_write_to_reg},
                {tbl[i].st, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].wd});
            chk($sformatf("tbl%0d_m0", i), {m0_done, m0_rvalid, m0_busy, m0_overflow, m0_rdata},
                {tbl[i].e_m0, 1'b0, 8'h00});
            chk($sformatf("tbl%0d_m1", i), {m1_done, m1_rvalid, m1_busy, m1_overflow, m1_rdata},
                {tbl[i].e_m1, 1'b0, tbl[i].m1_rd});
            m0_reg_en = tbl[i].m0_en; m0_write_en = tbl[i].m0_we;
            m0_address = tbl[i].m0_a; m0_wdata = tbl[i].m0_d;
            m1_reg_en = tbl[i].m1_en; m1_write_en = tbl[i].m1_we;
            m1_address = tbl[i].m1_a; m1_wdata = tbl[i].m1_d;
            tick();
        end

        // m0 read-back of the earlier write; leaves last grant on master 0
        idle(); drv0(0, 8'h10, 8'h00); tick();
        idle(); tick();
        chk("m0rd_issue", {reg_en, write_en, address, grant_mon}, {1'b1, 1'b0, 8'h10, 2'b10});
        tick(); tick();
        chk("m0rd_data", {m0_rvalid, m0_rdata, m1_rvalid}, {1'b1, 8'hA5, 1'b0});
        tick();

        // tie with last grant = master 0: master 1 must go first
        drv0(1, 8'h03, 8'h33); drv1(1, 8'h04, 8'h44); tick();
        idle();
        chk("tie2_busy", {m0_busy, m1_busy}, 2'b11);
        tick();
        chk("tie2_first", {reg_en, write_en, address, data_write_to_reg, m1_done, m0_done, grant_mon},
            {1'b1, 1'b1, 8'h04, 8'h44, 1'b1, 1'b0, 2'b11});
        tick(); tick();
        chk("tie2_second", {reg_en, address, data_write_to_reg, m0_done, m1_done},
            {1'b1, 8'h03, 8'h33, 1'b1, 1'b0});
        tick(); tick();

        // overflow: three back-to-back m0 strobes while m1 holds the bank
        acc = 0; dn = 0; bad = 0;
        drv1(1, 8'h40, 8'h77); tick();
        idle(); tick();
        drv0(1, 8'h30, 8'h01); tick(); observe(acc, dn, bad);
        drv0(1, 8'h31, 8'h02); tick(); observe(acc, dn, bad);
        drv0(1, 8'h32, 8'h03); tick(); observe(acc, dn, bad);
        idle();
        chk("ovf_set", {m0_overflow, m1_overflow}, 2'b10);
        for (int k = 0; k < 7; k++) begin
            tick(); observe(acc, dn, bad);
        end
        chk("ovf_accesses", acc, 2);
        chk("ovf_done_cnt", dn, 2);
        chk("ovf_dropped", bad, 1'b0);
        chk("ovf_bank31", mem[8'h31], 8'h02);
        chk("ovf_sticky", m0_overflow, 1'b1);
        overflow_clr = 1; tick();
        overflow_clr = 0;
        chk("ovf_clr", {m0_overflow, m1_overflow}, 2'b00);

        // clear wins over a same-cycle overflow
        drv1(0, 8'h50, 8'h00); tick();
        idle(); drv0(1, 8'h60, 8'hAA); tick();
        drv0(1, 8'h61, 8'hBB); overflow_clr = 1; tick();
        chk("clr_prio", m0_overflow, 1'b0);
        idle(); drv0(1, 8'h62, 8'hCC); tick();
        idle();
        chk("ovf_rwait", m0_overflow, 1'b1);
        repeat (5) tick();
        overflow_clr = 1; tick();
        overflow_clr = 0; tick();

        // reset during RWAIT aborts the read and drops m0's pending request
        drv1(0, 8'h22, 8'h00); tick();
        idle(); tick();
        drv0(1, 8'h70, 8'h99); tick();
        idle();
        chk("rst_in_rwait", {state_mon, m0_busy}, {2'd2, 1'b1});
        resetb = 0; tick();
        chk("rst_all_zero",
            {m0_rdata, m1_rdata, m0_rvalid, m1_rvalid, m0_done, m1_done, m0_busy, m1_busy,
             m0_overflow, m1_overflow, address, data_write_to_reg, reg_en, write_en,
             grant_mon, state_mon}, 64'h0);
        resetb = 1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (m1_rvalid || m0_rvalid || reg_en || m0_done) pulses++;
        end
        chk("rst_no_activity", pulses, 0);

        // random traffic against the transaction model
        begin
            logic       s_v [2]; logic s_w [2];
            logic [7:0] s_a [2]; logic [7:0] s_d [2];
            logic [7:0] h_a, h_d; logic [7:0] h_rd [2];
            int         free_at, if_s, if_e, if_m, last, req_total, drain, n;
            int         req_cnt [2]; int done_cnt [2]; int rv_cnt [2];
            logic       eb [2]; logic en [2]; logic w; logic [7:0] a, d;
            seed = 8'($urandom_range(1, 255));
            do_reset();
            for (int i = 0; i < 256; i++) mmem[i] = init_val(8'(i), seed);
            for (int i = 0; i < NC; i++) begin
                e_ren[i] = 0; e_wen[i] = 0; e_a[i] = 0; e_d[i] = 0;
                e_done[i] = 0; e_rv[i] = 0; e_rd[i][0] = 0; e_rd[i][1] = 0;
            end
            for (int m = 0; m < 2; m++) begin
                s_v[m] = 0; s_w[m] = 0; s_a[m] = 0; s_d[m] = 0; h_rd[m] = 0;
                req_cnt[m] = 0; done_cnt[m] = 0; rv_cnt[m] = 0;
            end
            h_a = 0; h_d = 0; free_at = 0; if_s = 0; if_e = 0; if_m = 0; last = 1;
            req_total = 0; drain = 0; n = 0;
            while (n < NC - 8 && drain < 12) begin
                if (e_ren[n]) begin h_a = e_a[n]; h_d = e_d[n]; end
                for (int m = 0; m < 2; m++) begin
                    if (e_rv[n][m]) h_rd[m] = e_rd[n][m];
                    eb[m] = s_v[m] || (if_m == m && n >= if_s && n < if_e);
                end
                chk("rnd_bank", {reg_en, write_en, address, data_write_to_reg},
                    {e_ren[n], e_wen[n], h_a, h_d});
                chk("rnd_m0", {m0_done, m0_rvalid, m0_busy, m0_overflow, m0_rdata},
                    {e_done[n][0], e_rv[n][0], eb[0], 1'b0, h_rd[0]});
                chk("rnd_m1", {m1_done, m1_rvalid, m1_busy, m1_overflow, m1_rdata},
                    {e_done[n][1], e_rv[n][1], eb[1], 1'b0, h_rd[1]});
                done_cnt[0] += int'(m0_done); done_cnt[1] += int'(m1_done);
                rv_cnt[0]   += int'(m0_rvalid); rv_cnt[1] += int'(m1_rvalid);

                // arbitration decision for this cycle
                if (n >= free_at && (s_v[0] || s_v[1])) begin
                    int g;
                    g = (s_v[0] && s_v[1]) ? 1 - last : (s_v[1] ? 1 : 0);
                    e_ren[n+1] = 1; e_wen[n+1] = s_w[g];
                    e_a[n+1] = s_a[g]; e_d[n+1] = s_d[g];
                    if (s_w[g]) begin
                        e_done[n+1][g] = 1;
                        mmem[s_a[g]] = s_d[g];
                        free_at = n + 2;
                    end else begin
                        e_rv[n+3][g] = 1;
                        e_rd[n+3][g] = mmem[s_a[g]];
                        free_at = n + 3;
                    end
                    if_m = g; if_s = n + 1; if_e = free_at; last = g;
                    s_v[g] = 0;
                end

                idle();
                overflow_clr = ($urandom_range(0, 15) == 0);
                for (int m = 0; m < 2; m++) begin
                    en[m] = !eb[m] && req_total < 200 && ($urandom_range(0, 2) == 0);
                    if (en[m]) begin
                        w = 1'($urandom_range(0, 1));
                        a = 8'($urandom_range(0, 15));
                        d = 8'($urandom);
                        if (m == 0) drv0(w, a, d); else drv1(w, a, d);
                        s_v[m] = 1; s_w[m] = w; s_a[m] = a; s_d[m] = d;
                        req_cnt[m]++; req_total++;
                    end
                end
                tick();
                n++;
                if (req_total >= 200) drain++;
            end
            idle();
            chk("rnd_all_issued", req_total, 200);
            chk("rnd_cnt_m0", req_cnt[0], done_cnt[0] + rv_cnt[0]);
            chk("rnd_cnt_m1", req_cnt[1], done_cnt[1] + rv_cnt[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-master arbiter that shares the single register-bank port (address, data_write_to_reg, data_read_from_reg, reg_en, write_en) between the UART host interface (master 0) and the I2C host interface (master 1). Each master issues single-cycle strobes. The arbiter buffers one request per master, serialises the requests to the bank with round-robin priority, and returns read data to the requesting master with a valid pulse. It sits between the two host interfaces and the register bank in the top level.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width

Ports (reset is synchronous, active-low):
- clk  in  1  system clock; only clock
- resetb  in  1  synchronous active-low reset
- m0_address / m1_address  in  ADDR_W  request address, sampled when the matching reg_en is high
- m0_wdata / m1_wdata  in  DATA_W  write data, sampled with the strobe
- m0_reg_en / m1_reg_en  in  1  request strobe, one cycle per request
- m0_write_en / m1_write_en  in  1  1 = write, 0 = read; sampled with the strobe
- m0_rdata / m1_rdata  out  DATA_W  read return data; holds its value until the next read for that master
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse when the matching rdata is valid
- m0_done / m1_done  out  1  one-cycle pulse when a write has been issued to the bank
- m0_busy / m1_busy  out  1  high while that master has a pending or in-flight request
- m0_overflow / m1_overflow  out  1  sticky: a request was dropped
- overflow_clr  in  1  clears both overflow flags
- address  out  ADDR_W  bank address
- data_write_to_reg  out  DATA_W  bank write data
- data_read_from_reg  in  DATA_W  bank read data, valid one cycle after reg_en
- reg_en  out  1  bank access strobe
- write_en  out  1  bank write strobe
- grant_mon  out  2  {in_flight, granted_master}
- state_mon  out  2  FSM state encoding

## Operation
- Each master has one pending slot holding {addr, wdata, we, valid}.
  - A strobe loads the slot on the next edge.
  - If the slot is already valid and is not being granted in the same cycle, the new request is dropped and that master's overflow flag is set.
  - A strobe in the same cycle the slot is granted loads normally and does not overflow.
- FSM states and encoding:
  - IDLE = 0: if any slot is valid, select a master, copy its slot to the bank outputs, assert reg_en (and write_en if it is a write), clear the slot, go to ISSUE.
  - ISSUE = 1: bank strobes are high this cycle. For a write, pulse done and go to IDLE. For a read, go to RWAIT.
  - RWAIT = 2: capture data_read_from_reg into the granted master's rdata and pulse its rvalid, then go to IDLE.
  - Encoding 3 is unused; it recovers to IDLE.
- Arbitration:
  - Round-robin via a last_grant register; on a tie, the master not last granted wins.
  - last_grant resets to 1, so master 0 wins the first tie.
- address and data_write_to_reg hold their last issued value between accesses. reg_en and write_en are single-cycle pulses.
- busy for a master = its slot is valid OR it owns the in-flight access.
- overflow_clr has priority over a same-cycle overflow set, i.e. the flag ends cleared.
- write_en is never high without reg_en.

## Timing
- Reset values: every output is 0, including rdata, flags, and address/data_write_to_reg. The FSM is in IDLE and both slots are empty.
- Reset asserted mid-transaction aborts it: no done or rvalid is produced, and pending requests are discarded.
- Request latency, with the strobe in cycle 0:
  - slot valid in cycle 1;
  - bank reg_en high in cycle 2;
  - write: done in cycle 2;
  - read: bank data sampled at the end of cycle 3, rvalid and rdata valid in cycle 4.
- Throughput: a write occupies 2 cycles (IDLE, ISSUE); a read occupies 3 cycles (IDLE, ISSUE, RWAIT).
- A new grant can be made in the IDLE cycle immediately following ISSUE or RWAIT.
- Worst-case wait for one master, when both are continuously requesting, is one access by the other master.
- rvalid and done are registered pulses; they never overlap for the same master.

## Test plan
- Master 0 write: addr 0x10, data 0xA5 strobed in cycle 0 → reg_en=write_en=1 with address=0x10 and data_write_to_reg=0xA5 in cycle 2 only; m0_done pulses in cycle 2; m1 outputs stay 0.
- Master 1 read: bank model returns 0x3C for addr 0x22 → m1_rvalid in cycle 4 with m1_rdata=0x3C; write_en stays 0; m1_busy high in cycles 1–3.
- Simultaneous strobes: m0 write 0x01/0x11 and m1 read 0x02 in the same cycle after reset → m0 is issued first (cycle 2) and m1 second (cycle 4), with m1_rvalid in cycle 6. Repeating the tie with last_grant=0 → m1 is issued first.
- Overflow: m0 strobes in three consecutive cycles while m1 holds the bank → the third request is dropped, m0_overflow=1, and only two m0 accesses reach the bank. Pulsing overflow_clr → flag is 0.
- Reset mid-read: resetb low during RWAIT → no rvalid; on the next edge all outputs are 0, state_mon=0, and both busy signals are 0.
- Sustained traffic: 200 random requests from both masters with ≤1 outstanding per master → every read data value matches the bank model, and the per-master request count equals the done count plus the rvalid count.
